// File: rtl/nbcac_pkg.sv
// nbcac_pkg: shared widths, scheduler state type and payload group selector.
//   CHUNK_W   - data bits per NBCAC group
//   CODE_W    - wires per NBCAC codeword
//   MAX_CHUNK - widest payload the selector can slice (groups)
package nbcac_pkg;

    localparam int CHUNK_W   = 7;
    localparam int CODE_W    = 10;
    localparam int MAX_CHUNK = 16;

    typedef enum logic {IDLE, SEND} state_t;

    // Payload is zero-extended to MAX_CHUNK groups by the caller, so one
    // selector serves every legal N_CHUNK.
    function automatic logic [CHUNK_W-1:0] chunk_sel(
        input logic [CHUNK_W*MAX_CHUNK-1:0] data,
        input logic [3:0]                   idx
    );
        return data[CHUNK_W*idx +: CHUNK_W];
    endfunction

endpackage

// File: rtl/nbcac_7di_encoder_core.sv
// nbcac_7di_encoder_core: combinational 7-bit to 10-wire NBCAC encoder.
//   v[6:0]  - data group
//   d[10:1] - codeword; wires 3, 6 and 9 are grounded shields, so every data
//             wire has at most one switching data neighbour
module nbcac_7di_encoder_core (
    input  logic [6:0]  v,
    output logic [10:1] d
);

    assign d = {v[6], 1'b0, v[5], v[4], 1'b0, v[3], v[2], 1'b0, v[1], v[0]};

endmodule

// File: rtl/nbcac_tx_scheduler.sv
// nbcac_tx_scheduler: slices payload words into 7-bit groups and streams their NBCAC codewords.
//   clock, rst             - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      - payload handshake, in_data holds N_CHUNK groups, LSB group first
//   code_valid/code_ready  - codeword handshake towards the bus driver
//   codeout                - registered codeword, held while stalled or idle
//   code_first/code_last   - codeout carries group 0 / group N_CHUNK-1
//   busy                   - a word is buffered or a codeword is pending
module nbcac_tx_scheduler
    import nbcac_pkg::*;
#(
    parameter int N_CHUNK = 4
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHUNK_W*N_CHUNK-1:0] in_data,
    output logic                       code_valid,
    input  logic                       code_ready,
    output logic [CODE_W:1]            codeout,
    output logic                       code_first,
    output logic                       code_last,
    output logic                       busy
);

    localparam int            IW   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_CHUNK - 1);

    state_t                       state, state_d;
    logic [IW-1:0]                idx, idx_d;
    logic [CHUNK_W*N_CHUNK-1:0]   buffer;
    logic [CHUNK_W*MAX_CHUNK-1:0] buffer_pad;
    logic [CHUNK_W-1:0]           chunk;
    logic [CODE_W:1]              code;
    logic                         slot_free, at_last, accept, load;

    assign slot_free  = !code_valid || code_ready;
    assign at_last    = idx == LAST;
    // A new word may enter on the very edge that loads the last group, which
    // keeps back-to-back words bubble-free.
    assign in_ready   = !rst && (state == IDLE || (at_last && slot_free));
    assign accept     = in_valid && in_ready;
    assign load       = state == SEND && slot_free;
    assign busy       = state != IDLE || code_valid;
    assign buffer_pad = (CHUNK_W*MAX_CHUNK)'(buffer);
    assign chunk      = chunk_sel(buffer_pad, 4'(idx));

    nbcac_7di_encoder_core u_enc (
        .v (chunk),
        .d (code)
    );

    always_comb begin
        state_d = accept ? SEND : (load && at_last) ? IDLE : state;
        idx_d   = accept ? '0 : (load && !at_last) ? idx + 1'b1 : idx;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            buffer     <= '0;
            codeout    <= '0;
            code_valid <= 1'b0;
            code_first <= 1'b0;
            code_last  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (accept)
                buffer <= in_data;
            // codeout is only ever written with a fresh codeword, so the bus
            // sees no transitions while stalled or idle.
            if (load) begin
                codeout    <= code;
                code_valid <= 1'b1;
                code_first <= idx == '0;
                code_last  <= at_last;
            end else if (code_ready) begin
                code_valid <= 1'b0;
            end
        end
    end

endmodule
